// File: rtl/ecc_mem_bank_scrub.sv
// SECDED-protected memory bank: corrected registered reads, a background scrubber
// that rewrites single-bit-error words, and saturating error statistics.
module ecc_mem_bank_scrub #(
   parameter int DATA_W         = 20,
   parameter int ADDR_W         = 6,
   parameter int SCRUB_INTERVAL = 256,
   parameter int CNT_W          = 8,
   localparam int P  = (DATA_W <= 1)   ? 2 :
                       (DATA_W <= 4)   ? 3 :
                       (DATA_W <= 11)  ? 4 :
                       (DATA_W <= 26)  ? 5 :
                       (DATA_W <= 57)  ? 6 :
                       (DATA_W <= 120) ? 7 : 8,
   localparam int CW = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [CW-1:0]     inj_mask,
   input  logic              scrub_en,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              err_corr,
   output logic              err_uncorr,
   output logic              scrub_busy,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt,
   output logic [ADDR_W-1:0] bad_addr
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int IW    = $clog2(SCRUB_INTERVAL + 1);
   localparam logic [IW-1:0] RELOAD = IW'(SCRUB_INTERVAL - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD, S_WB} state_t;

   // Codeword layout: bit 0 overall parity, powers of two are check bits, data fills the rest in order.
   function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CW-1:0] c;
      int j;
      c = '0;
      j = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos] = d[j];
            j++;
         end
      end
      for (int p = 0; p < P; p++) begin
         for (int pos = 1; pos < CW; pos++) begin
            if ((((pos >> p) & 1) == 1) && (pos != (1 << p)))
               c[1 << p] = c[1 << p] ^ c[pos];
         end
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
      logic [DATA_W-1:0] d;
      int j;
      d = '0;
      j = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = c[pos];
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [P-1:0] syndrome_of(input logic [CW-1:0] c);
      logic [P-1:0] s;
      s = '0;
      for (int pos = 1; pos < CW; pos++)
         if (c[pos]) s = s ^ P'(pos);
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic a, input logic b);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(a) + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   logic [CW-1:0]     mem [DEPTH];
   logic [CW-1:0]     rd_word_reg;
   logic [ADDR_W-1:0] rd_addr_reg;
   logic              rd_pend_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              rvalid_reg, err_corr_reg, err_uncorr_reg;
   logic [CNT_W-1:0]  corr_cnt_reg, uncorr_cnt_reg;
   logic [ADDR_W-1:0] bad_addr_reg;

   state_t            state_reg, state_next;
   logic [IW-1:0]     ivl_reg, ivl_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [CW-1:0]     fix_reg, fix_next;
   logic              sc_wr, sc_corr_ev, sc_unc_ev;

   logic [P-1:0]      rd_syn, sc_syn;
   logic              rd_perr, sc_perr, rd_corr_ev, rd_unc_ev;
   logic [CW-1:0]     sc_word;

   assign rd_syn     = syndrome_of(rd_word_reg);
   assign rd_perr    = ^rd_word_reg;
   assign rd_corr_ev = rd_pend_reg & rd_perr;
   assign rd_unc_ev  = rd_pend_reg & ~rd_perr & (rd_syn != '0);

   assign sc_word = mem[ptr_reg];
   assign sc_syn  = syndrome_of(sc_word);
   assign sc_perr = ^sc_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= encode('0);
      end else if (we) begin
         mem[addr] <= encode(wdata) ^ inj_mask;
      end else if (sc_wr) begin
         mem[ptr_reg] <= fix_reg;
      end
   end

   // Read is captured at the strobe edge (read-first) and decoded into the output registers one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_reg <= 1'b0;
      end else begin
         rd_pend_reg <= re;
         if (re) begin
            rd_word_reg <= mem[addr];
            rd_addr_reg <= addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg      <= '0;
         rvalid_reg     <= 1'b0;
         err_corr_reg   <= 1'b0;
         err_uncorr_reg <= 1'b0;
         corr_cnt_reg   <= '0;
         uncorr_cnt_reg <= '0;
         bad_addr_reg   <= '0;
      end else begin
         rvalid_reg <= rd_pend_reg;
         if (rd_pend_reg) begin
            rdata_reg      <= extract(rd_perr ? (rd_word_reg ^ (CW'(1) << rd_syn)) : rd_word_reg);
            err_corr_reg   <= rd_perr;
            err_uncorr_reg <= rd_unc_ev;
         end
         corr_cnt_reg   <= sat_add(corr_cnt_reg, rd_corr_ev, sc_corr_ev);
         uncorr_cnt_reg <= sat_add(uncorr_cnt_reg, rd_unc_ev, sc_unc_ev);
         if (rd_unc_ev)      bad_addr_reg <= rd_addr_reg;
         else if (sc_unc_ev) bad_addr_reg <= ptr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         ivl_reg   <= '0;
         ptr_reg   <= '0;
         fix_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ivl_reg   <= ivl_next;
         ptr_reg   <= ptr_next;
         fix_reg   <= fix_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ivl_next   = ivl_reg;
      ptr_next   = ptr_reg;
      fix_next   = fix_reg;
      sc_wr      = 1'b0;
      sc_corr_ev = 1'b0;
      sc_unc_ev  = 1'b0;
      if (!scrub_en) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               state_next = S_WAIT;
               ivl_next   = RELOAD;
            end
            S_WAIT: begin
               if (ivl_reg == '0) state_next = S_RD;
               else               ivl_next   = ivl_reg - IW'(1);
            end
            S_RD: begin
               if (!we && !re) begin
                  if (sc_perr) begin
                     sc_corr_ev = 1'b1;
                     fix_next   = sc_word ^ (CW'(1) << sc_syn);
                     state_next = S_WB;
                  end else begin
                     sc_unc_ev  = (sc_syn != '0);
                     ptr_next   = ptr_reg + ADDR_W'(1);
                     ivl_next   = RELOAD;
                     state_next = S_WAIT;
                  end
               end
            end
            S_WB: begin
               // A user write to the same word supersedes the scrubbed copy.
               if (!we || (addr == ptr_reg)) begin
                  sc_wr      = !we;
                  ptr_next   = ptr_reg + ADDR_W'(1);
                  ivl_next   = RELOAD;
                  state_next = S_WAIT;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign rdata      = rdata_reg;
   assign rvalid     = rvalid_reg;
   assign err_corr   = err_corr_reg;
   assign err_uncorr = err_uncorr_reg;
   assign scrub_busy = (state_reg == S_RD) || (state_reg == S_WB);
   assign corr_cnt   = corr_cnt_reg;
   assign uncorr_cnt = uncorr_cnt_reg;
   assign bad_addr   = bad_addr_reg;

endmodule

// File: tb/tb_ecc_mem_bank_scrub.sv
// Bench for ecc_mem_bank_scrub: directed scenarios plus randomized write/read traffic
// checked against a per-word model of stored data and injected flip count.
module tb_ecc_mem_bank_scrub;
   localparam int DW = 20, AW = 6, CWB = 26, CNTW = 8, INTERVAL = 4;

   logic            clk = 1'b0;
   logic            rst, we, re, scrub_en;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [CWB-1:0]  inj_mask;
   logic [DW-1:0]   rdata;
   logic            rvalid, err_corr, err_uncorr, scrub_busy;
   logic [CNTW-1:0] corr_cnt, uncorr_cnt;
   logic [AW-1:0]   bad_addr;

   int total = 0, bad = 0;

   // model: each word holds its data plus how many bits were flipped by injection
   logic [DW-1:0] m_data [64];
   int            m_flips [64];
   int            exp_corr, exp_unc;
   logic [AW-1:0] exp_bad;

   ecc_mem_bank_scrub #(.DATA_W(DW), .ADDR_W(AW), .SCRUB_INTERVAL(INTERVAL), .CNT_W(CNTW)) dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
      .inj_mask(inj_mask), .scrub_en(scrub_en), .rdata(rdata), .rvalid(rvalid),
      .err_corr(err_corr), .err_uncorr(err_uncorr), .scrub_busy(scrub_busy),
      .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .bad_addr(bad_addr)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         m_data[i]  = '0;
         m_flips[i] = 0;
      end
      exp_corr = 0;
      exp_unc  = 0;
      exp_bad  = '0;
   endtask

   task automatic model_read(input int a, output logic [DW-1:0] ed, output logic ec, output logic eu);
      ed = m_data[a];
      ec = (m_flips[a] == 1);
      eu = (m_flips[a] == 2);
      if (ec) exp_corr++;
      if (eu) begin
         exp_unc++;
         exp_bad = AW'(a);
      end
   endtask

   // double flips are kept on check-bit positions so the raw data bits stay intact
   function automatic logic [CWB-1:0] rand_mask(input int kind);
      int chk[6] = '{0, 1, 2, 4, 8, 16};
      logic [CWB-1:0] m;
      int i, j;
      m = '0;
      if (kind == 1) begin
         m[$urandom_range(CWB-1, 0)] = 1'b1;
      end else if (kind == 2) begin
         i = int'($urandom_range(5, 0));
         j = (i + int'($urandom_range(5, 1))) % 6;
         m[chk[i]] = 1'b1;
         m[chk[j]] = 1'b1;
      end
      return m;
   endfunction

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; re = 1'b0; scrub_en = 1'b0; inj_mask = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic write_word(input int a, input logic [DW-1:0] d, input logic [CWB-1:0] m);
      we = 1'b1; addr = AW'(a); wdata = d; inj_mask = m;
      @(posedge clk); #1;
      we = 1'b0; inj_mask = '0;
      m_data[a]  = d;
      m_flips[a] = $countones(m);
   endtask

   task automatic read_word(input int a, output logic [DW-1:0] d, output logic c, output logic u,
                            output logic v_early, output logic v);
      re = 1'b1; addr = AW'(a);
      @(posedge clk); #1;
      re = 1'b0;
      v_early = rvalid;
      @(posedge clk); #1;
      d = rdata; c = err_corr; u = err_uncorr; v = rvalid;
   endtask

   task automatic test_reset();
      logic [DW-1:0] d; logic c, u, ve, v;
      rst = 1'b1; we = 1'b1; re = 1'b1; addr = 6'd12; wdata = 20'hFFFFF; inj_mask = '0; scrub_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; we = 1'b0; re = 1'b0;
      model_clear();
      total++;
      if ({rvalid, err_corr, err_uncorr, scrub_busy, corr_cnt, uncorr_cnt, bad_addr, rdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got rv=%b ec=%b eu=%b busy=%b cc=%0d uc=%0d ba=%0d rd=%h, want all 0",
                  rvalid, err_corr, err_uncorr, scrub_busy, corr_cnt, uncorr_cnt, bad_addr, rdata);
      end
      for (int a = 0; a < 64; a++) begin
         read_word(a, d, c, u, ve, v);
         total++;
         if ({d, c, u, ve, v} !== {20'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_read a=%0d: got d=%h c=%b u=%b early=%b v=%b, want d=0 c=0 u=0 early=0 v=1",
                     a, d, c, u, ve, v);
         end
      end
      $display("reset: 64 words read back");
   endtask

   task automatic test_clean();
      logic [DW-1:0] d; logic c, u, ve, v;
      write_word(5, 20'hA5A5A, '0);
      read_word(5, d, c, u, ve, v);
      total++;
      if ({d, c, u, ve, v} !== {20'hA5A5A, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL clean_read: got d=%h c=%b u=%b early=%b v=%b, want d=a5a5a c=0 u=0 early=0 v=1",
                  d, c, u, ve, v);
      end
      @(posedge clk); #1;
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rvalid_pulse: got %b want 0", rvalid);
      end
      $display("clean: addr 5 d=%h", d);
   endtask

   task automatic test_single();
      logic [DW-1:0] d, ed; logic c, u, ve, v, ec, eu;
      for (int k = 0; k < 2; k++) begin
         write_word(9, 20'h12345, (k == 0) ? CWB'(1) << 7 : CWB'(1));
         read_word(9, d, c, u, ve, v);
         model_read(9, ed, ec, eu);
         total++;
         if ({d, c, u, v} !== {ed, ec, eu, 1'b1} || c !== 1'b1) begin
            bad++;
            $display("FAIL single_read k=%0d: got d=%h c=%b u=%b v=%b, want d=%h c=1 u=0 v=1", k, d, c, u, v, ed);
         end
         total++;
         if (corr_cnt !== CNTW'(exp_corr)) begin
            bad++;
            $display("FAIL single_cnt k=%0d: got %0d want %0d", k, corr_cnt, exp_corr);
         end
         $display("single k=%0d: d=%h corr_cnt=%0d", k, d, corr_cnt);
      end
   endtask

   task automatic test_double();
      logic [DW-1:0] d, ed; logic c, u, ve, v, ec, eu;
      write_word(63, 20'h0F0F0, CWB'(3));
      read_word(63, d, c, u, ve, v);
      model_read(63, ed, ec, eu);
      total++;
      if ({d, c, u, v} !== {ed, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL double_read: got d=%h c=%b u=%b v=%b, want d=%h c=0 u=1 v=1", d, c, u, v, ed);
      end
      total++;
      if ({uncorr_cnt, bad_addr} !== {CNTW'(exp_unc), 6'd63}) begin
         bad++;
         $display("FAIL double_stats: got uc=%0d ba=%0d want uc=%0d ba=63", uncorr_cnt, bad_addr, exp_unc);
      end
      $display("double: uc=%0d ba=%0d", uncorr_cnt, bad_addr);
   endtask

   task automatic test_random();
      logic [DW-1:0] d, ed, nd; logic c, u, ve, v, ec, eu;
      logic [CWB-1:0] nm;
      int a, op;
      for (int it = 0; it < 40; it++) begin
         a  = int'($urandom_range(63, 0));
         op = int'($urandom_range(2, 0));
         nd = DW'($urandom);
         nm = rand_mask(int'($urandom_range(2, 0)));
         if (op == 0) begin
            write_word(a, nd, nm);
            read_word(a, d, c, u, ve, v);
         end else if (op == 1) begin
            read_word(a, d, c, u, ve, v);
         end else begin
            // same-cycle write and read: the read must see the old word
            we = 1'b1; re = 1'b1; addr = AW'(a); wdata = nd; inj_mask = nm;
            @(posedge clk); #1;
            we = 1'b0; re = 1'b0; inj_mask = '0;
            @(posedge clk); #1;
            d = rdata; c = err_corr; u = err_uncorr; v = rvalid;
         end
         model_read(a, ed, ec, eu);
         if (op == 2) begin
            m_data[a]  = nd;
            m_flips[a] = $countones(nm);
         end
         total++;
         if ({d, c, u, v} !== {ed, ec, eu, 1'b1}) begin
            bad++;
            $display("FAIL rand_read it=%0d op=%0d a=%0d: got d=%h c=%b u=%b v=%b, want d=%h c=%b u=%b v=1",
                     it, op, a, d, c, u, v, ed, ec, eu);
         end
         total++;
         if ({corr_cnt, uncorr_cnt, bad_addr} !== {CNTW'(sat(exp_corr)), CNTW'(sat(exp_unc)), exp_bad}) begin
            bad++;
            $display("FAIL rand_stats it=%0d: got cc=%0d uc=%0d ba=%0d want cc=%0d uc=%0d ba=%0d",
                     it, corr_cnt, uncorr_cnt, bad_addr, sat(exp_corr), sat(exp_unc), exp_bad);
         end
         $display("rand it=%0d op=%0d a=%0d d=%h c=%b u=%b", it, op, a, d, c, u);
      end
   endtask

   task automatic test_scrub();
      logic [DW-1:0] d; logic c, u, ve, v;
      logic seen_busy, seen_unc;
      logic [AW-1:0] first_bad;
      do_reset();
      write_word(3, 20'h5A5A5, CWB'(1) << 10);
      write_word(40, 20'h11111, CWB'(5));
      scrub_en = 1'b1;
      seen_busy = 1'b0; seen_unc = 1'b0; first_bad = '0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(posedge clk); #1;
         if (scrub_busy) seen_busy = 1'b1;
         if (!seen_unc && uncorr_cnt != 0) begin
            seen_unc  = 1'b1;
            first_bad = bad_addr;
         end
      end
      total++;
      if (seen_busy !== 1'b1) begin
         bad++;
         $display("FAIL scrub_busy_seen: got %b want 1", seen_busy);
      end
      total++;
      if ({seen_unc, first_bad} !== {1'b1, 6'd40}) begin
         bad++;
         $display("FAIL scrub_uncorr: got seen=%b ba=%0d want seen=1 ba=40", seen_unc, first_bad);
      end
      total++;
      if (corr_cnt !== 8'd1) begin
         bad++;
         $display("FAIL scrub_corr_cnt: got %0d want 1", corr_cnt);
      end
      scrub_en = 1'b0;
      @(posedge clk); #1;
      total++;
      if (scrub_busy !== 1'b0) begin
         bad++;
         $display("FAIL scrub_disable: busy got %b want 0", scrub_busy);
      end
      read_word(3, d, c, u, ve, v);
      total++;
      if ({d, c, u, v, corr_cnt} !== {20'h5A5A5, 1'b0, 1'b0, 1'b1, 8'd1}) begin
         bad++;
         $display("FAIL scrub_fixed: got d=%h c=%b u=%b v=%b cc=%0d want d=5a5a5 c=0 u=0 v=1 cc=1",
                  d, c, u, v, corr_cnt);
      end
      $display("scrub: cc=%0d uc=%0d first_ba=%0d", corr_cnt, uncorr_cnt, first_bad);
   endtask

   task automatic test_contention();
      logic [DW-1:0] d; logic c, u, ve, v;
      do_reset();
      write_word(0, 20'h77777, CWB'(1) << 12);
      write_word(20, 20'h02222, '0);
      re = 1'b1; addr = 6'd20; scrub_en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if ({scrub_busy, corr_cnt, rdata} !== {1'b1, 8'd0, 20'h02222}) begin
         bad++;
         $display("FAIL contend_hold: got busy=%b cc=%0d rd=%h want busy=1 cc=0 rd=02222", scrub_busy, corr_cnt, rdata);
      end
      re = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({scrub_busy, corr_cnt} !== {1'b1, 8'd1}) begin
         bad++;
         $display("FAIL contend_fetch: got busy=%b cc=%0d want busy=1 cc=1", scrub_busy, corr_cnt);
      end
      we = 1'b1; addr = 6'd0; wdata = 20'h3C3C3; inj_mask = '0;
      @(posedge clk); #1;
      we = 1'b0;
      total++;
      if (scrub_busy !== 1'b0) begin
         bad++;
         $display("FAIL contend_drop: busy got %b want 0", scrub_busy);
      end
      scrub_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      read_word(0, d, c, u, ve, v);
      total++;
      if ({d, c, u, v} !== {20'h3C3C3, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL contend_user_data: got d=%h c=%b u=%b v=%b want d=3c3c3 c=0 u=0 v=1", d, c, u, v);
      end
      $display("contention: addr 0 d=%h", d);
   endtask

   task automatic test_saturation();
      logic [DW-1:0] d; logic c, u, ve, v;
      do_reset();
      write_word(7, 20'h0ABCD, CWB'(1) << 3);
      re = 1'b1; addr = 6'd7;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk); #1;
         if (k == 100) begin
            total++;
            if (corr_cnt !== 8'd99) begin
               bad++;
               $display("FAIL sat_mid: got %0d want 99", corr_cnt);
            end
         end
      end
      re = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({corr_cnt, uncorr_cnt, rdata} !== {8'd255, 8'd0, 20'h0ABCD}) begin
         bad++;
         $display("FAIL sat_full: got cc=%0d uc=%0d rd=%h want cc=255 uc=0 rd=0abcd", corr_cnt, uncorr_cnt, rdata);
      end
      @(posedge clk); #1;
      re = 1'b1; addr = 6'd7;
      @(posedge clk); #1;
      re = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      total++;
      if ({rvalid, corr_cnt, uncorr_cnt} !== {1'b0, 8'd0, 8'd0}) begin
         bad++;
         $display("FAIL rst_midread: got rv=%b cc=%0d uc=%0d want rv=0 cc=0 uc=0", rvalid, corr_cnt, uncorr_cnt);
      end
      @(posedge clk); #1;
      total++;
      if (rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_late_rvalid: got %b want 0", rvalid);
      end
      read_word(7, d, c, u, ve, v);
      total++;
      if ({d, c, u, v, corr_cnt} !== {20'h0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
         bad++;
         $display("FAIL rst_mem_cleared: got d=%h c=%b u=%b v=%b cc=%0d want d=0 c=0 u=0 v=1 cc=0",
                  d, c, u, v, corr_cnt);
      end
      $display("saturation/reset: d=%h cc=%0d", d, corr_cnt);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; scrub_en = 1'b0;
      addr = '0; wdata = '0; inj_mask = '0;
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_random();
      test_scrub();
      test_contention();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
